// File: rtl/block_state_ctrl_if.sv
// Request/response and store-side signals of the block-state sequencer.
// The controller sits on the slave modport; the requesters and the
// store model together sit on the master modport.
interface block_state_ctrl_if;
  // store side
  logic [12:0] line;
  logic [12:0] new_line;
  logic        write_line;
  logic        next_line;
  // renderer
  logic        rd_req;
  logic [3:0]  rd_row;
  logic        rd_ack;
  logic [12:0] rd_data;
  // ball/collision logic
  logic        hit_req;
  logic [3:0]  hit_row;
  logic [3:0]  hit_col;
  logic        hit_ack;
  logic        hit_was_set;
  // status
  logic [7:0]  blocks_left;
  logic        all_clear;

  modport slave (
    input  line, rd_req, rd_row, hit_req, hit_row, hit_col,
    output new_line, write_line, next_line, rd_ack, rd_data,
           hit_ack, hit_was_set, blocks_left, all_clear
  );

  modport master (
    output line, rd_req, rd_row, hit_req, hit_row, hit_col,
    input  new_line, write_line, next_line, rd_ack, rd_data,
           hit_ack, hit_was_set, blocks_left, all_clear
  );
endinterface

// File: rtl/block_state_ctrl.sv
// Sequencer for the rotating block-state store. Arbitrates renderer reads
// and brick hits, rotates the store to the requested row, serves the
// request, clears hit bricks and tracks how many bricks remain.
module block_state_ctrl #(
  parameter int NUM_ROWS    = 15,
  parameter int INIT_BLOCKS = 91
) (
  input  logic              clk,
  input  logic              nRst,
  block_state_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEEK, RD_ACK, WRITE, NOP_ACK} state_t;

  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'd12;

  state_t      state_q, state_d;
  logic [3:0]  ptr_q;
  logic [3:0]  tgt_row_q;
  logic [3:0]  tgt_col_q;
  logic        is_hit_q;
  logic        rr_last_hit_q;
  logic [12:0] rd_data_q;
  logic        hit_was_set_q;
  logic [7:0]  blocks_q;

  logic        any_req;
  logic        grant_hit;
  logic [3:0]  req_row;
  logic        req_bad;
  logic        at_target;

  logic        next_line;
  logic        write_line;
  logic [12:0] new_line;
  logic        rd_ack;
  logic        hit_ack;

  // Round-robin: on a tie, the requester not granted last time wins.
  assign any_req   = bus.rd_req | bus.hit_req;
  assign grant_hit = bus.hit_req & (~bus.rd_req | ~rr_last_hit_q);
  assign req_row   = grant_hit ? bus.hit_row : bus.rd_row;
  assign req_bad   = (req_row > LAST_ROW) || (grant_hit && (bus.hit_col > LAST_COL));
  assign at_target = (ptr_q == tgt_row_q);

  // Next-state and store/ack strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    next_line  = 1'b0;
    write_line = 1'b0;
    new_line   = 13'd0;
    rd_ack     = 1'b0;
    hit_ack    = 1'b0;
    unique case (state_q)
      IDLE:    if (any_req) state_d = req_bad ? NOP_ACK : SEEK;
      SEEK: begin
        if (!at_target) next_line = 1'b1;
        else            state_d   = is_hit_q ? WRITE : RD_ACK;
      end
      RD_ACK: begin
        rd_ack  = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        hit_ack = 1'b1;
        if (hit_was_set_q) begin
          write_line = 1'b1;
          new_line   = bus.line & ~(13'd1 << tgt_col_q);
        end
        state_d = IDLE;
      end
      NOP_ACK: begin
        if (is_hit_q) hit_ack = 1'b1;
        else          rd_ack  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Visible-row pointer; follows every rotation pulse sent to the store.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)          ptr_q <= 4'd0;
    else if (next_line) ptr_q <= (ptr_q == LAST_ROW) ? 4'd0 : ptr_q + 4'd1;
  end

  // Latch the granted request and remember who won arbitration.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tgt_row_q     <= 4'd0;
      tgt_col_q     <= 4'd0;
      is_hit_q      <= 1'b0;
      rr_last_hit_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      tgt_row_q     <= req_row;
      tgt_col_q     <= bus.hit_col;
      is_hit_q      <= grant_hit;
      rr_last_hit_q <= grant_hit;
    end
  end

  // Result registers: cleared on grant, loaded from the store on arrival.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rd_data_q     <= 13'd0;
      hit_was_set_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      if (grant_hit) hit_was_set_q <= 1'b0;
      else           rd_data_q     <= 13'd0;
    end else if (state_q == SEEK && at_target) begin
      if (is_hit_q) hit_was_set_q <= bus.line[tgt_col_q];
      else          rd_data_q     <= bus.line;
    end
  end

  // Remaining-brick counter, saturating at zero.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      blocks_q <= 8'(INIT_BLOCKS);
    else if (state_q == WRITE && hit_was_set_q && blocks_q != 8'd0)
      blocks_q <= blocks_q - 8'd1;
  end

  assign bus.next_line   = next_line;
  assign bus.write_line  = write_line;
  assign bus.new_line    = new_line;
  assign bus.rd_ack      = rd_ack;
  assign bus.hit_ack     = hit_ack;
  assign bus.rd_data     = rd_data_q;
  assign bus.hit_was_set = hit_was_set_q;
  assign bus.blocks_left = blocks_q;
  assign bus.all_clear   = (blocks_q == 8'd0);

endmodule

// File: tb/tb_block_state_ctrl.sv
// Bench for block_state_ctrl: a rotating-store model plus a row-array
// reference of the brick field, driven by directed and random requests.
module tb_block_state_ctrl;

  logic clk  = 1'b0;
  logic nRst = 1'b0;

  block_state_ctrl_if bus ();

  block_state_ctrl #(.NUM_ROWS(15), .INIT_BLOCKS(91)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Store model: 15 rows, rows 8..14 full at reset, one row visible.
  logic [12:0] store [15];
  int          sptr;
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 15; i++) store[i] <= (i >= 8) ? 13'h1FFF : 13'h0000;
      sptr <= 0;
    end else if (bus.write_line) begin
      store[sptr] <= bus.new_line;
    end else if (bus.next_line) begin
      sptr <= (sptr == 14) ? 0 : sptr + 1;
    end
  end
  assign bus.line = store[sptr];

  // Store-port monitor.
  int          n_next = 0;
  int          n_write = 0;
  int          viol = 0;
  logic [12:0] last_new = 13'd0;
  always @(posedge clk) begin
    if (nRst) begin
      if (bus.next_line) n_next <= n_next + 1;
      if (bus.write_line) begin
        n_write  <= n_write + 1;
        last_new <= bus.new_line;
      end
      if (bus.write_line && bus.next_line) viol <= viol + 1;
      if (!bus.write_line && bus.new_line != 13'd0) viol <= viol + 1;
      if (bus.rd_ack && bus.hit_ack) viol <= viol + 1;
    end
  end

  // Reference: brick field as rows, visible row index, count, last winner.
  logic [12:0] ref_rows [15];
  int          ref_ptr;
  int          ref_blocks;
  bit          ref_last_hit;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 15; i++) ref_rows[i] = (i >= 8) ? 13'h1FFF : 13'h0000;
    ref_ptr      = 0;
    ref_blocks   = 91;
    ref_last_hit = 1'b1;
  endtask

  function automatic bit req_valid(input bit hit, input int row, input int col);
    return (row < 15) && (!hit || col <= 12);
  endfunction

  // Expected response: read data, or the brick flag in bit 0.
  function automatic logic [12:0] ref_expect(input bit hit, input int row, input int col);
    logic [12:0] r;
    if (!req_valid(hit, row, col)) return 13'd0;
    r = ref_rows[row];
    if (hit) return {12'd0, r[col]};
    return r;
  endfunction

  task automatic ref_apply(input bit hit, input int row, input int col);
    ref_last_hit = hit;
    if (req_valid(hit, row, col)) begin
      ref_ptr = row;
      if (hit && ref_rows[row][col]) begin
        ref_rows[row][col] = 1'b0;
        if (ref_blocks > 0) ref_blocks--;
      end
    end
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.rd_ack || bus.hit_ack) begin
        who = bus.hit_ack ? 1 : 0;
        cyc = k;
        break;
      end
    end
  endtask

  task automatic drive(input bit hit, input bit req, input int row, input int col);
    if (hit) begin
      bus.hit_req = req;
      bus.hit_row = 4'(row);
      bus.hit_col = 4'(col);
    end else begin
      bus.rd_req = req;
      bus.rd_row = 4'(row);
    end
  endtask

  // One isolated request with full latency / store-access checking.
  task automatic do_req(input bit hit, input int row, input int col, input string tag);
    bit          valid;
    int          d, who, cyc, nx0, wr0, exp_blocks;
    logic [12:0] exp_val, exp_new, obs_val;
    bit          exp_flag;
    valid      = req_valid(hit, row, col);
    d          = valid ? (row - ref_ptr + 15) % 15 : 0;
    exp_val    = ref_expect(hit, row, col);
    exp_flag   = hit && exp_val[0];
    exp_new    = exp_flag ? (ref_rows[row] & ~(13'd1 << col)) : 13'd0;
    exp_blocks = (exp_flag && ref_blocks > 0) ? ref_blocks - 1 : ref_blocks;
    nx0 = n_next;
    wr0 = n_write;
    @(negedge clk);
    drive(hit, 1'b1, row, col);
    wait_ack(who, cyc);
    obs_val = hit ? {12'd0, bus.hit_was_set} : bus.rd_data;
    drive(hit, 1'b0, row, col);
    check({tag, " ack_who"}, who, hit ? 1 : 0);
    check({tag, " latency"}, cyc, valid ? d + 2 : 1);
    check({tag, " data"}, obs_val, exp_val);
    @(negedge clk);
    check({tag, " idle_no_ack"}, {bus.rd_ack, bus.hit_ack}, 0);
    check({tag, " next_pulses"}, n_next - nx0, d);
    check({tag, " writes"}, n_write - wr0, exp_flag ? 1 : 0);
    if (exp_flag) check({tag, " new_line"}, last_new, exp_new);
    check({tag, " blocks_left"}, bus.blocks_left, exp_blocks);
    check({tag, " all_clear"}, bus.all_clear, exp_blocks == 0);
    ref_apply(hit, row, col);
  endtask

  initial begin
    int who, cyc, rrow, hrow, hcol, win, wrow, wcol, acks;
    logic [12:0] exp_val, obs_val;

    bus.rd_req = 1'b0; bus.rd_row = 4'd0;
    bus.hit_req = 1'b0; bus.hit_row = 4'd0; bus.hit_col = 4'd0;
    ref_reset();
    repeat (2) @(negedge clk);
    check("reset rd_ack", bus.rd_ack, 0);
    check("reset hit_ack", bus.hit_ack, 0);
    check("reset store_strobes", {bus.write_line, bus.next_line}, 0);
    check("reset new_line", bus.new_line, 0);
    check("reset rd_data", bus.rd_data, 0);
    check("reset hit_was_set", bus.hit_was_set, 0);
    check("reset blocks_left", bus.blocks_left, 91);
    check("reset all_clear", bus.all_clear, 0);
    nRst = 1'b1;

    // Reads at the current row, at the far end, and across the wrap.
    do_req(0, 0, 0, "t1 rd0");
    do_req(0, 14, 0, "t2 rd14");
    do_req(0, 0, 0, "t2 rd0wrap");

    // Hit a brick, then the same (now empty) position again.
    do_req(1, 14, 0, "t3 hit");
    do_req(1, 14, 0, "t3 rehit");

    // Both requesters pending; each winner re-raises after its ack twice.
    rrow = $urandom_range(0, 14);
    hrow = $urandom_range(0, 14);
    hcol = $urandom_range(0, 12);
    @(negedge clk);
    drive(0, 1'b1, rrow, 0);
    drive(1, 1'b1, hrow, hcol);
    for (int step = 0; step < 4; step++) begin
      win     = ref_last_hit ? 0 : 1;
      wrow    = win ? hrow : rrow;
      wcol    = win ? hcol : 0;
      exp_val = ref_expect(win[0], wrow, wcol);
      wait_ack(who, cyc);
      obs_val = (who == 1) ? {12'd0, bus.hit_was_set} : bus.rd_data;
      drive(win[0], 1'b0, wrow, wcol);
      check($sformatf("t4 grant%0d", step), who, win);
      check($sformatf("t4 data%0d", step), obs_val, exp_val);
      ref_apply(win[0], wrow, wcol);
      @(negedge clk);
      check($sformatf("t4 idle_no_ack%0d", step), {bus.rd_ack, bus.hit_ack}, 0);
      if (step < 2) begin
        if (win == 1) begin
          hrow = $urandom_range(0, 14);
          hcol = $urandom_range(0, 12);
          drive(1, 1'b1, hrow, hcol);
        end else begin
          rrow = $urandom_range(0, 14);
          drive(0, 1'b1, rrow, 0);
        end
      end
    end
    check("t4 blocks_left", bus.blocks_left, ref_blocks);

    // Out-of-range row and column.
    do_req(0, 15, 0, "t5 rd15");
    do_req(1, 3, 13, "t5 col13");

    // Random mix, including out-of-range requests.
    for (int i = 0; i < 12; i++)
      do_req($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 13),
             $sformatf("rand%0d", i));

    // Clear every remaining brick.
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 13; c++)
        if (ref_rows[r][c]) do_req(1, r, c, $sformatf("t6 clr r%0d c%0d", r, c));
    check("t6 blocks_left", bus.blocks_left, 0);
    check("t6 all_clear", bus.all_clear, 1);
    do_req(1, 9, 5, "t6 empty_hit");

    // Reset in the middle of a long seek.
    @(negedge clk);
    drive(0, 1'b1, (ref_ptr + 14) % 15, 0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rd_ack || bus.hit_ack) acks++;
    end
    check("t6 in_seek", bus.next_line, 1);
    nRst = 1'b0;
    drive(0, 1'b0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;
    ref_reset();
    repeat (5) begin
      @(negedge clk);
      if (bus.rd_ack || bus.hit_ack || bus.next_line || bus.write_line) acks++;
    end
    check("t6 rst no_ack", acks, 0);
    check("t6 rst blocks_left", bus.blocks_left, 91);
    check("t6 rst all_clear", bus.all_clear, 0);
    check("t6 rst rd_data", bus.rd_data, 0);
    do_req(0, 0, 0, "t6 rst rd0");
    do_req(0, 14, 0, "t6 rst rd14");

    check("store protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
